// File: rtl/wb_uart_host_master.sv
// Wishbone classic-cycle initiator for the UART register port: one command in,
// one single-beat bus cycle, one response out (read data or timeout error).
module wb_uart_host_master #(
  parameter int         TIMEOUT = 256,
  parameter logic [3:0] SEL_VAL = 4'b1111
) (
  input  logic       clk,
  input  logic       wb_rst_i,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_we,
  input  logic [4:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic [4:0] wb_addr_o,
  output logic [3:0] wb_sel_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  output logic       wb_we_o,
  output logic       wb_stb_o,
  output logic       wb_cyc_o,
  input  logic       wb_ack_i
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic             timeout_hit;

  logic       cyc_nxt, stb_nxt, we_nxt;
  logic [4:0] addr_nxt;
  logic [3:0] sel_nxt;
  logic [7:0] dat_nxt;
  logic       rsp_valid_nxt, rsp_err_nxt;
  logic [7:0] rsp_rdata_nxt;

  assign cmd_ready = (state == IDLE);

  // Saturating BUS-cycle count; timeout only armed when TIMEOUT is non-zero.
  assign cnt_inc     = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_inc >= TO_VAL);

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    cyc_nxt       = wb_cyc_o;
    stb_nxt       = wb_stb_o;
    we_nxt        = wb_we_o;
    addr_nxt      = wb_addr_o;
    sel_nxt       = wb_sel_o;
    dat_nxt       = wb_dat_o;
    rsp_valid_nxt = rsp_valid;
    rsp_err_nxt   = rsp_err;
    rsp_rdata_nxt = rsp_rdata;

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_nxt = BUS;
          cnt_nxt   = '0;
          cyc_nxt   = 1'b1;
          stb_nxt   = 1'b1;
          we_nxt    = cmd_we;
          addr_nxt  = cmd_addr;
          sel_nxt   = SEL_VAL;
          dat_nxt   = cmd_we ? cmd_wdata : 8'h00;
        end
      end

      BUS: begin
        cnt_nxt = cnt_inc;
        // An ack on the timeout edge still completes the cycle normally.
        if (wb_ack_i || timeout_hit) begin
          state_nxt     = RESP;
          cyc_nxt       = 1'b0;
          stb_nxt       = 1'b0;
          we_nxt        = 1'b0;
          addr_nxt      = 5'h00;
          sel_nxt       = 4'h0;
          dat_nxt       = 8'h00;
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = !wb_ack_i;
          rsp_rdata_nxt = (wb_ack_i && !wb_we_o) ? wb_dat_i : 8'h00;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_nxt     = IDLE;
          cnt_nxt       = '0;
          rsp_valid_nxt = 1'b0;
          rsp_err_nxt   = 1'b0;
          rsp_rdata_nxt = 8'h00;
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_addr_o <= 5'h00;
      wb_sel_o  <= 4'h0;
      wb_dat_o  <= 8'h00;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 8'h00;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      wb_cyc_o  <= cyc_nxt;
      wb_stb_o  <= stb_nxt;
      wb_we_o   <= we_nxt;
      wb_addr_o <= addr_nxt;
      wb_sel_o  <= sel_nxt;
      wb_dat_o  <= dat_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_err   <= rsp_err_nxt;
      rsp_rdata <= rsp_rdata_nxt;
    end
  end

endmodule

// File: tb/tb_wb_uart_host_master.sv
// Directed bench for wb_uart_host_master with a response scoreboard and a
// scripted Wishbone slave (wait states, timeout, ack-on-timeout, reset abort).
module tb_wb_uart_host_master;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       wb_rst_i = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_we = 1'b0;
  logic [4:0] cmd_addr = 5'h00;
  logic [7:0] cmd_wdata = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic [4:0] wb_addr_o;
  logic [3:0] wb_sel_o;
  logic [7:0] wb_dat_o;
  logic [7:0] wb_dat_i = 8'hEE;
  logic       wb_we_o;
  logic       wb_stb_o;
  logic       wb_cyc_o;
  logic       wb_ack_i = 1'b0;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
  } rsp_t;

  rsp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  wb_uart_host_master #(.TIMEOUT(TO), .SEL_VAL(4'b1111)) dut (
    .clk       (clk),
    .wb_rst_i  (wb_rst_i),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .wb_addr_o (wb_addr_o),
    .wb_sel_o  (wb_sel_o),
    .wb_dat_o  (wb_dat_o),
    .wb_dat_i  (wb_dat_i),
    .wb_we_o   (wb_we_o),
    .wb_stb_o  (wb_stb_o),
    .wb_cyc_o  (wb_cyc_o),
    .wb_ack_i  (wb_ack_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bus_word();
    return 32'({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_addr_o, wb_dat_o});
  endfunction

  function automatic logic [31:0] idle_outs();
    return 32'({bus_word(), rsp_valid, rsp_err, rsp_rdata, cmd_ready});
  endfunction

  // Issue one command at a negedge and play the slave; ack after 'waits' wait
  // states, or never when do_ack is 0. Ends at the negedge after cyc drops.
  task automatic bus_cycle(input logic we, input logic [4:0] addr, input logic [7:0] wdata,
                           input int waits, input logic [7:0] slave_data, input bit do_ack);
    rsp_t e;
    int   stb_cnt;
    logic [31:0] bus_exp;
    e.rdata = (do_ack && !we) ? slave_data : 8'h00;
    e.err   = !do_ack;
    bus_exp = 32'({1'b1, 1'b1, we, 4'b1111, addr, we ? wdata : 8'h00});
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    exp_q.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_wdata = 8'h77;
    stb_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      if (!wb_cyc_o) break;
      stb_cnt++;
      chk("bus_held", bus_word(), bus_exp);
      chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
      if (do_ack && c == waits + 1) begin
        wb_ack_i = 1'b1;
        wb_dat_i = slave_data;
      end
      @(negedge clk);
      wb_ack_i = 1'b0;
      wb_dat_i = 8'hEE;
    end
    chk("stb_cycles", 32'(stb_cnt), do_ack ? 32'(waits + 1) : 32'(TO));
    chk("bus_dropped", bus_word(), 32'd0);
    chk("rsp_latency", 32'(rsp_valid), 32'd1);
  endtask

  // Hold the response 'hold' cycles, then accept it and compare with the scoreboard.
  task automatic take_rsp(input int hold);
    rsp_t e;
    int   waited;
    logic [8:0] held;
    waited = 0;
    while (!rsp_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("rsp_arrived", 32'(rsp_valid), 32'd1);
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
    chk("rsp_err", 32'(rsp_err), 32'(e.err));
    held = {rsp_err, rsp_rdata};
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("rsp_hold", 32'({rsp_valid, rsp_err, rsp_rdata}), 32'({1'b1, held}));
      chk("hold_no_cmd", 32'({cmd_ready, wb_cyc_o}), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_cleared", 32'({rsp_valid, rsp_err, rsp_rdata}), 32'd0);
    chk("cmd_ready_back", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("reset_outs", idle_outs(), 32'd1);
    wb_rst_i = 1'b0;
    @(negedge clk);
    chk("post_reset_outs", idle_outs(), 32'd1);

    // Write with one wait state; slave drives junk on dat_i which must be ignored
    bus_cycle(1'b1, 5'h03, 8'h83, 1, 8'h5A, 1'b1);
    take_rsp(0);

    // Read with three wait states
    bus_cycle(1'b0, 5'h05, 8'h00, 3, 8'h60, 1'b1);
    take_rsp(0);

    // Zero-wait read, top address
    bus_cycle(1'b0, 5'h1F, 8'h00, 0, 8'hC3, 1'b1);
    take_rsp(0);

    // Timeout: slave never acks
    bus_cycle(1'b0, 5'h02, 8'h00, 0, 8'h00, 1'b0);
    take_rsp(0);

    // Ack lands on the same edge the timeout is reached
    bus_cycle(1'b0, 5'h07, 8'h00, TO - 1, 8'hA5, 1'b1);
    take_rsp(0);

    // Backpressure with a command pending during the hold
    bus_cycle(1'b1, 5'h01, 8'h3C, 0, 8'h00, 1'b1);
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_addr  = 5'h06;
    take_rsp(5);
    chk("pending_not_taken", 32'(wb_cyc_o), 32'd0);
    bus_cycle(1'b0, 5'h06, 8'h00, 2, 8'h9B, 1'b1);
    take_rsp(0);

    // Reset in the middle of a bus cycle; no response for the aborted command
    chk("cmd_ready_pre_abort", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_we    = 1'b1;
    cmd_addr  = 5'h04;
    cmd_wdata = 8'hF0;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("abort_bus_up", 32'(wb_cyc_o & wb_stb_o), 32'd1);
    @(negedge clk);
    #2 wb_rst_i = 1'b1;
    #1;
    chk("abort_async_clear", idle_outs(), 32'd1);
    @(negedge clk);
    wb_rst_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_no_rsp", idle_outs(), 32'd1);

    // A fresh command works after the abort
    bus_cycle(1'b0, 5'h00, 8'h00, 1, 8'h11, 1'b1);
    take_rsp(0);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
